// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared constants and state encoding for the mux scan controller
// Purpose: channel count, select width and FSM state type used by
//          mux_scan_ctrl and mux_scan_next.
package mux_scan_ctrl_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/mux_scan_next.sv
// rtl/mux_scan_next.sv - round-robin channel search over an enable mask
// Purpose: combinational search shared by the start and advance paths.
// Ports:
//   en    in   enable mask, bit n = channel n
//   cur   in   current channel
//   nxt   out  next enabled channel strictly after cur, wrapping; cur if none other
//   wrap  out  nxt <= cur (sweep wrapped or single channel)
//   first out  lowest enabled channel
module mux_scan_next
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NCH-1:0]   en,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic [SEL_W-1:0] first
);

  always_comb begin
    first = '0;
    nxt   = cur;
    // Scan from the far end so the lowest match is assigned last and wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      if (en[k]) first = SEL_W'(k);
    end
    // Offsets 3..1 from cur; the SEL_W-bit sum wraps mod NCH by itself.
    // Offset 0 (cur alone enabled) is covered by the nxt = cur default.
    for (int k = NCH - 1; k >= 1; k--) begin
      if (en[cur + SEL_W'(k)]) nxt = cur + SEL_W'(k);
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin select scanner and sampler for a 4:1 mux
// Purpose: steps {s1,s0} over the enabled channels, holds each for a dwell,
//          samples y on the last edge of the window and publishes the result.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, stop            scan control (start only in idle, stop at end of dwell)
//   chan_en, dwell         channel mask and per-channel dwell, latched at start
//   y                      mux output being sampled
//   s0, s1                 mux select
//   busy                   scanning
//   sample_valid/_chan/_bit  one-cycle sample strobe with channel and value
//   snapshot               latest sample per channel
//   sweep_done             one-cycle strobe on the last sample of a sweep
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4,
  parameter bit ONESHOT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     chan_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s0,
  output logic               s1,
  output logic               busy,
  output logic               sample_valid,
  output logic [SEL_W-1:0]   sample_chan,
  output logic               sample_bit,
  output logic [NCH-1:0]     snapshot,
  output logic               sweep_done
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [NCH-1:0]     en_q;
  logic               stop_req;

  logic [NCH-1:0]     srch_en;
  logic [SEL_W-1:0]   srch_nxt;
  logic [SEL_W-1:0]   srch_first;
  logic               srch_wrap;

  logic               start_ok;
  logic               sample_edge;
  logic               finish;

  // In idle the search looks at the live mask (for the start channel);
  // while scanning it walks the latched mask.
  assign srch_en = (state == ST_IDLE) ? chan_en : en_q;

  mux_scan_next u_next (
    .en    (srch_en),
    .cur   (ptr),
    .nxt   (srch_nxt),
    .wrap  (srch_wrap),
    .first (srch_first)
  );

  assign start_ok    = (state == ST_IDLE) && start && (|chan_en);
  assign sample_edge = (state == ST_DWELL) && (cnt == dwell_q - 1'b1);
  assign finish      = sample_edge && (stop_req || (ONESHOT && srch_wrap));

  assign s0 = ptr[0];
  assign s1 = ptr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_DWELL;
      ST_DWELL: if (finish)   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      cnt          <= '0;
      dwell_q      <= '0;
      en_q         <= '0;
      stop_req     <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_bit   <= 1'b0;
      snapshot     <= '0;
      sweep_done   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sweep_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            en_q     <= chan_en;
            dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
            ptr      <= srch_first;
            cnt      <= '0;
            busy     <= 1'b1;
            stop_req <= 1'b0;
          end
        end
        ST_DWELL: begin
          cnt <= cnt + 1'b1;
          if (stop) stop_req <= 1'b1;
          if (sample_edge) begin
            snapshot[ptr] <= y;
            sample_bit    <= y;
            sample_chan   <= ptr;
            sample_valid  <= 1'b1;
            sweep_done    <= srch_wrap;
            if (finish) begin
              // Leaving the scan: the select stays on the last channel.
              busy     <= 1'b0;
              stop_req <= 1'b0;
            end else begin
              ptr <= srch_nxt;
              cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
